// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the multicycle ALU.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Mul always iterates; div iterates unless the divisor is zero.
    function automatic logic needs_iter(input logic [1:0] op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/result bundle between a requester (master) and the multicycle ALU (slave).
interface multicycle_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    // start is sampled only while busy=0; it is ignored otherwise. done pulses for
    // one cycle when Y/Z/O/C/dz become final, and those hold until the next done.
    logic             start;
    logic [1:0]       OPCode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Z;
    logic             O;
    logic             C;
    logic             busy;
    logic             done;
    logic             dz;
    state_t           state;

    modport master (
        output start, OPCode, A, B,
        input  Y, Z, O, C, busy, done, dz, state
    );

    modport slave (
        input  start, OPCode, A, B,
        output Y, Z, O, C, busy, done, dz, state
    );

endinterface

// File: rtl/alu_iter_core.sv
// Shared shift/accumulate datapath: shift-add multiply and restoring divide, one step per cycle.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_next_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   b_q;
    logic               div_q;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_rem;
    logic               div_ge;

    // hi holds the partial product / remainder, lo the multiplier / quotient bits.
    always_comb begin
        hi        = acc_q[2*WIDTH-1:WIDTH];
        lo        = acc_q[WIDTH-1:0];
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        div_trial = {hi, lo[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, b_q});
        div_rem   = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
        acc_d     = acc_q;
        if (div_q) begin
            acc_d = {div_rem[WIDTH-1:0], lo[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= {{WIDTH{1'b0}}, a_i};
            b_q   <= b_i;
            div_q <= div_i;
        end else if (step_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_next_o = acc_d;

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle add/sub, WIDTH-iteration mul/div through alu_iter_core.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    multicycle_alu_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   z_q;
    logic               o_q;
    logic               c_q;
    logic               dz_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH:0]     add_d;
    logic [WIDTH:0]     sub_d;
    logic               add_ovf_d;
    logic               sub_ovf_d;
    logic               iter_load;
    logic               iter_step;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        add_d     = {1'b0, bus.A} + {1'b0, bus.B};
        sub_d     = {1'b0, bus.A} - {1'b0, bus.B};
        add_ovf_d = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_d[WIDTH-1] != bus.A[WIDTH-1]);
        sub_ovf_d = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_d[WIDTH-1] != bus.A[WIDTH-1]);
    end

    assign iter_load = (state_q == ST_IDLE) && bus.start && needs_iter(bus.OPCode, bus.B == '0);
    assign iter_step = (state_q == ST_RUN);

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (iter_load),
        .step_i     (iter_step),
        .div_i      (bus.OPCode == OP_DIV),
        .a_i        (bus.A),
        .b_i        (bus.B),
        .acc_next_o (acc_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            o_q     <= 1'b0;
            c_q     <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.OPCode;
                        busy_q <= 1'b1;
                        if (iter_load) begin
                            state_q <= ST_RUN;
                            cnt_q   <= CW'(WIDTH - 1);
                        end else begin
                            // Add, sub and divide-by-zero resolve on the accept edge.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            case (bus.OPCode)
                                OP_ADD: begin
                                    y_q  <= add_d[WIDTH-1:0];
                                    z_q  <= '0;
                                    c_q  <= add_d[WIDTH];
                                    o_q  <= add_ovf_d;
                                    dz_q <= 1'b0;
                                end
                                OP_SUB: begin
                                    y_q  <= sub_d[WIDTH-1:0];
                                    z_q  <= '0;
                                    c_q  <= sub_d[WIDTH];
                                    o_q  <= sub_ovf_d;
                                    dz_q <= 1'b0;
                                end
                                default: begin
                                    y_q  <= '1;
                                    z_q  <= bus.A;
                                    c_q  <= 1'b0;
                                    o_q  <= 1'b0;
                                    dz_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == '0) begin
                        // Final iteration result goes straight into the output registers.
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        y_q     <= acc_next[WIDTH-1:0];
                        z_q     <= acc_next[2*WIDTH-1:WIDTH];
                        o_q     <= (op_q == OP_MUL) && (acc_next[2*WIDTH-1:WIDTH] != '0);
                        c_q     <= 1'b0;
                        dz_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Y     = y_q;
    assign bus.Z     = z_q;
    assign bus.O     = o_q;
    assign bus.C     = c_q;
    assign bus.dz    = dz_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed literal cases plus randomized ops vs an arithmetic model.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int RW = 2 * W + 3;

  logic clock;
  logic reset_n;

  int errors = 0;
  int checks = 0;

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [RW-1:0] model_res(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int ua;
    int ub;
    int sa;
    int sb;
    int s;
    int p;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic o;
    logic c;
    logic dz;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    y = '0; z = '0; o = 1'b0; c = 1'b0; dz = 1'b0;
    case (op)
      2'd0: begin
        y = W'(ua + ub);
        c = (ua + ub) >= (1 << W);
        s = sa + sb;
        o = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      end
      2'd1: begin
        y = W'(ua - ub);
        c = ua < ub;
        s = sa - sb;
        o = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      end
      2'd2: begin
        p = ua * ub;
        y = W'(p);
        z = W'(p >> W);
        o = (z != '0);
      end
      default: begin
        if (ub == 0) begin
          y = '1;
          z = a;
          dz = 1'b1;
        end else begin
          y = W'(ua / ub);
          z = W'(ua % ub);
        end
      end
    endcase
    return {y, z, o, c, dz};
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] b);
    return (op == 2'd2 || (op == 2'd3 && b != '0)) ? W + 1 : 1;
  endfunction

  function automatic logic [RW-1:0] dut_res();
    return {bus.Y, bus.Z, bus.O, bus.C, bus.dz};
  endfunction

  // rem = cycles of busy still to come; rem==1 is the done cycle.
  int rem = 0;
  logic [RW-1:0] pend;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] hold = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem = 0;
      exp_q.delete();
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 1) exp_q.push_back(pend);
    end else if (bus.start) begin
      pend = model_res(bus.OPCode, bus.A, bus.B);
      rem  = model_lat(bus.OPCode, bus.B);
      if (rem == 1) exp_q.push_back(pend);
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      hold = '0;
    end else begin
      chk("busy", 64'(bus.busy), 64'(rem > 0));
      chk("done", 64'(bus.done), 64'(rem == 1));
      if (rem == 1 && exp_q.size() > 0) hold = exp_q.pop_front();
      chk("outputs", 64'(dut_res()), 64'(hold));
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [RW-1:0] res, output int lat);
    int guard;
    guard = 0;
    while (bus.busy && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) chk("idle_timeout", 64'(1), 64'(0));
    bus.start  = 1'b1;
    bus.OPCode = op;
    bus.A      = a;
    bus.B      = b;
    lat = 0;
    res = '0;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clock);
      if (k == 1) begin
        bus.start  = 1'b0;
        bus.A      = W'($urandom);
        bus.B      = W'($urandom);
        bus.OPCode = 2'($urandom);
      end
      if (bus.done) begin
        lat = k;
        res = dut_res();
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 64'(1), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [RW-1:0] res;
  int lat;
  logic [1:0] rop;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.OPCode = '0;
    bus.A      = '0;
    bus.B      = '0;

    // Model pinned against hand-computed values.
    chk("model_add",  64'(model_res(OP_ADD, 8'h7F, 8'h05)), 64'({8'h84, 8'h00, 3'b100}));
    chk("model_sub",  64'(model_res(OP_SUB, 8'h04, 8'h05)), 64'({8'hFF, 8'h00, 3'b010}));
    chk("model_mul",  64'(model_res(OP_MUL, 8'h7F, 8'h08)), 64'({8'hF8, 8'h03, 3'b100}));
    chk("model_div0", 64'(model_res(OP_DIV, 8'h04, 8'h00)), 64'({8'hFF, 8'h04, 3'b001}));

    repeat (2) @(negedge clock);
    chk("reset_outputs", 64'(dut_res()), 64'(0));
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_state", 64'(bus.state), 64'(ST_IDLE));
    #2 reset_n = 1'b1;
    @(negedge clock);

    do_op(OP_ADD, 8'h13, 8'h2C, res, lat);
    chk("add1_res", 64'(res), 64'({8'h3F, 8'h00, 3'b000}));
    chk("add1_lat", 64'(lat), 64'(1));
    do_op(OP_ADD, 8'h7F, 8'h05, res, lat);
    chk("add2_res", 64'(res), 64'({8'h84, 8'h00, 3'b100}));
    chk("add2_lat", 64'(lat), 64'(1));
    do_op(OP_SUB, 8'h80, 8'h01, res, lat);
    chk("sub1_res", 64'(res), 64'({8'h7F, 8'h00, 3'b100}));
    do_op(OP_SUB, 8'h04, 8'h05, res, lat);
    chk("sub2_res", 64'(res), 64'({8'hFF, 8'h00, 3'b010}));
    do_op(OP_MUL, 8'h7F, 8'h08, res, lat);
    chk("mul_res", 64'(res), 64'({8'hF8, 8'h03, 3'b100}));
    chk("mul_lat", 64'(lat), 64'(9));
    do_op(OP_DIV, 8'h7F, 8'h08, res, lat);
    chk("div_res", 64'(res), 64'({8'h0F, 8'h07, 3'b000}));
    chk("div_lat", 64'(lat), 64'(9));
    do_op(OP_DIV, 8'h04, 8'h00, res, lat);
    chk("div0_res", 64'(res), 64'({8'hFF, 8'h04, 3'b001}));
    chk("div0_lat", 64'(lat), 64'(1));

    // start pulsed mid-mul must be ignored.
    @(negedge clock);
    bus.start = 1'b1; bus.OPCode = OP_MUL; bus.A = 8'h0C; bus.B = 8'h0B;
    lat = 0;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clock);
      bus.start = (k == 3);
      if (k == 3) begin
        bus.OPCode = OP_ADD; bus.A = 8'h01; bus.B = 8'h01;
      end
      if (bus.done) begin
        lat = k;
        res = dut_res();
        break;
      end
    end
    bus.start = 1'b0;
    chk("ignore_res", 64'(res), 64'({8'h84, 8'h00, 3'b000}));
    chk("ignore_lat", 64'(lat), 64'(9));

    // Reset at RUN cycle 4 aborts with no done pulse.
    @(negedge clock);
    @(negedge clock);
    bus.start = 1'b1; bus.OPCode = OP_MUL; bus.A = 8'hFF; bus.B = 8'hFF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("abort_outputs", 64'(dut_res()), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_state", 64'(bus.state), 64'(ST_IDLE));
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (12) @(negedge clock);
    do_op(OP_ADD, 8'h13, 8'h2C, res, lat);
    chk("post_reset_res", 64'(res), 64'({8'h3F, 8'h00, 3'b000}));
    chk("post_reset_lat", 64'(lat), 64'(1));

    // Randomized operations.
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      do_op(rop, ra, rb, res, lat);
      chk("rand_res", 64'(res), 64'(model_res(rop, ra, rb)));
      chk("rand_lat", 64'(lat), 64'(model_lat(rop, rb)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal values 4..32.
REQ-002 Port clock  in  1: single clock; all state changes on its rising edge.
REQ-003 Port reset_n  in  1: asynchronous, active-low reset.
REQ-004 Port start  in  1: request; sampled only on rising edges of clock while in IDLE.
REQ-005 Port OPCode  in  2: 00 add, 01 sub, 10 unsigned mul, 11 unsigned div.
REQ-006 Port A  in  WIDTH: first operand / dividend.
REQ-007 Port B  in  WIDTH: second operand / divisor.
REQ-008 Port Y  out  WIDTH: sum, difference, product low half, or quotient.
REQ-009 Port Z  out  WIDTH: product high half or remainder; 0 for add/sub.
REQ-010 Port O  out  1: overflow flag, per REQ-019..REQ-022.
REQ-011 Port C  out  1: carry/borrow flag, per REQ-019..REQ-022.
REQ-012 Port busy  out  1: high in every state except IDLE.
REQ-013 Port done  out  1: single-cycle pulse; Y/Z/O/C/dz valid and final.
REQ-014 Port dz  out  1: divide-by-zero indicator; meaningful with done for OPCode 11.

Function
REQ-015 FSM states: IDLE, RUN, DONE; encoding lives in the shared package.
REQ-016 IDLE with start=1 at an edge: A, B, OPCode latched that edge; later operand changes have no effect on the operation.
REQ-017 Add/sub, and div with B=0: IDLE->DONE; done high exactly 1 cycle after the accept edge.
REQ-018 Mul and div with B!=0: IDLE->RUN for WIDTH cycles (one iteration per cycle, internal counter WIDTH-1 down to 0), then DONE; done high WIDTH+1 cycles after the accept edge.
REQ-019 Add: Y=(A+B) mod 2^WIDTH; C=carry out; O=signed two's-complement overflow; Z=0.
REQ-020 Sub: Y=(A-B) mod 2^WIDTH; C=1 when A<B unsigned (borrow); O=signed overflow; Z=0.
REQ-021 Mul: {Z,Y}=A*B unsigned, iterative shift-add; O=1 when Z!=0; C=0.
REQ-022 Div: Y=A/B, Z=A mod B, restoring iterative division; O=0, C=0, dz=0; with B=0: Y=all ones, Z=A, dz=1, O=0, C=0.
REQ-023 DONE always returns to IDLE on the next edge; done lasts exactly one cycle; minimum start-to-start spacing is 2 cycles for add/sub.
REQ-024 start while busy=1 is ignored; there is no queueing, and the in-flight operation and outputs are unaffected.
REQ-025 Y, Z, O, C, dz update only on entry to DONE and hold until the next DONE or reset; intermediate iteration values never appear on the outputs.
REQ-026 Result registers are 2*WIDTH wide internally; no truncation before output split.

Reset
REQ-027 reset_n low asynchronously forces IDLE; Y=0, Z=0, O=0, C=0, dz=0, busy=0, done=0; internal counter and operand registers are cleared.
REQ-028 Reset mid-RUN aborts the operation with no done pulse; the first start after reset_n rises is accepted normally.

Structure
REQ-029 Package alu_pkg holds the OPCode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state type/encoding.
REQ-030 Sub-module alu_iter_core holds the shared shift register/accumulator datapath for mul and div; add/sub and the FSM stay in multicycle_alu.

Verification (WIDTH=8)
REQ-031 Add A=0x13 B=0x2C, then A=0x7F B=0x05 -> Y=0x3F C=0 O=0; then Y=0x84 C=0 O=1; each done 1 cycle after accept.
REQ-032 Sub A=0x80 B=0x01 -> Y=0x7F O=1 C=0; sub A=0x04 B=0x05 -> Y=0xFF C=1 O=0.
REQ-033 Mul A=0x7F B=0x08 -> Y=0xF8 Z=0x03 O=1; done exactly 9 cycles after accept; busy high throughout.
REQ-034 Div A=0x7F B=0x08 -> Y=0x0F Z=0x07 dz=0 after 9 cycles; div A=0x04 B=0x00 -> Y=0xFF Z=0x04 dz=1 after 1 cycle.
REQ-035 start pulsed with new operands during a mul -> ignored; the original result is delivered unchanged.
REQ-036 reset_n low at RUN cycle 4 -> all outputs 0 immediately; no done pulse; the next add completes normally.
